// File: rtl/fifo_zero_wr_arb_pkg.sv
// Shared constants and helpers for the zero-width FIFO write-side scheduler.
package fifo_zero_wr_arb_pkg;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned CNTWIDTH_DEF = 4;
  localparam int unsigned NREQ_MAX     = 16;

  // Index width for a set of n items; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic logic [NREQ_MAX-1:0] onehot(input int unsigned idx);
    return NREQ_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_zero_wr_arb_if.sv
// Requester/FIFO-side signal bundle for the scheduler; slave is the scheduler view.
interface fifo_zero_wr_arb_if
  import fifo_zero_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = clog2(NREQ)
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] busy;
  logic            we;
  logic [NREQ-1:0] grant;
  logic            full;
  logic            err;
  logic [IW-1:0]   err_id;

  modport master (output req, full, input busy, we, grant, err, err_id);
  modport slave  (input req, full, output busy, we, grant, err, err_id);
endinterface

// File: rtl/fifo_zero_wr_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index starting at ptr, wrapping.
module fifo_zero_wr_arb_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_c_o,
  output logic [IW-1:0] pick_c_o
);

  // Scan from the farthest offset back to ptr so the closest eligible index wins.
  always_comb begin
    int unsigned idx;
    valid_c_o = 1'b0;
    pick_c_o  = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (32'(ptr_i) + 32'(k)) % N;
      if (elig_i[idx]) begin
        valid_c_o = 1'b1;
        pick_c_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_zero_wr_arb.sv
// Round-robin write scheduler for a zero-width async FIFO: per-requester pending
// counters, one write strobe per cycle, full-flag throttling and sticky drop error.
module fifo_zero_wr_arb
  import fifo_zero_wr_arb_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned CNTWIDTH = CNTWIDTH_DEF
) (
  input logic               clk,
  input logic               reset_l,
  fifo_zero_wr_arb_if.slave wr_if
);

  localparam int unsigned IW = clog2(NREQ);
  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

  logic [CNTWIDTH-1:0] pend_q [NREQ];
  logic [CNTWIDTH-1:0] pend_d [NREQ];
  logic [IW-1:0]       ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     busy_q, busy_d;
  logic                err_q, err_d;
  logic [IW-1:0]       err_id_q, err_id_d;

  logic [NREQ-1:0]     elig_c, dec_c, drop_c;
  logic                valid_c;
  logic [IW-1:0]       pick_c;

  always_comb begin
    for (int i = 0; i < NREQ; i++) elig_c[i] = (pend_q[i] != '0);
  end

  fifo_zero_wr_arb_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .elig_i    (elig_c),
    .ptr_i     (ptr_q),
    .valid_c_o (valid_c),
    .pick_c_o  (pick_c)
  );

  // Decision, counter update and first-drop capture.
  always_comb begin
    dec_c    = '0;
    drop_c   = '0;
    we_d     = 1'b0;
    grant_d  = '0;
    ptr_d    = ptr_q;
    err_d    = err_q;
    err_id_d = err_id_q;

    if (valid_c && !wr_if.full) begin
      dec_c   = NREQ'(onehot(32'(pick_c)));
      we_d    = 1'b1;
      grant_d = dec_c;
      ptr_d   = (pick_c == IW'(NREQ - 1)) ? '0 : pick_c + IW'(1);
    end

    for (int i = 0; i < NREQ; i++) begin
      pend_d[i] = pend_q[i];
      if (wr_if.req[i] && !dec_c[i]) begin
        if (pend_q[i] == CNT_MAX) drop_c[i] = 1'b1;
        else                      pend_d[i] = pend_q[i] + CNTWIDTH'(1);
      end else if (dec_c[i] && !wr_if.req[i]) begin
        pend_d[i] = pend_q[i] - CNTWIDTH'(1);
      end
      busy_d[i] = (pend_d[i] == CNT_MAX);
    end

    if (drop_c != '0) err_d = 1'b1;
    // Descending scan leaves the lowest simultaneous drop index.
    if (!err_q) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (drop_c[i]) err_id_d = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NREQ; i++) pend_q[i] <= '0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      grant_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) pend_q[i] <= pend_d[i];
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign wr_if.we     = we_q;
  assign wr_if.grant  = grant_q;
  assign wr_if.busy   = busy_q;
  assign wr_if.err    = err_q;
  assign wr_if.err_id = err_id_q;

endmodule

// File: tb/tb_fifo_zero_wr_arb.sv
// Bench for fifo_zero_wr_arb: vector table, directed corner sequences, random vs model.
module tb_fifo_zero_wr_arb;

  localparam int MAXC = 15;

  logic clk;
  logic reset_l;

  fifo_zero_wr_arb_if #(.NREQ(4), .IW(2)) bus ();

  fifo_zero_wr_arb #(.NREQ(4), .CNTWIDTH(4)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .wr_if   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       we;
    logic [3:0] grant;
  } vec_t;

  vec_t tbl [15];

  int         m_pend [4];
  int         m_ptr;
  logic       m_we;
  logic [3:0] m_grant;
  logic       m_err;
  logic [1:0] m_err_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_l  = 1'b0;
    bus.req  = '0;
    bus.full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_l = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_ptr = 0; m_we = 0; m_grant = '0; m_err = 0; m_err_id = '0;
  endtask

  // Issue first, then accept new events; an event that finds its count already at max is lost.
  task automatic model_step(input logic [3:0] r, input logic f);
    int pick;
    int j;
    pick = -1;
    if (!f) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (pick < 0 && m_pend[j] > 0) pick = j;
      end
    end
    m_we    = (pick >= 0);
    m_grant = '0;
    if (pick >= 0) begin
      m_grant[pick] = 1'b1;
      m_pend[pick]  = m_pend[pick] - 1;
      m_ptr         = (pick + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        if (m_pend[i] < MAXC) m_pend[i] = m_pend[i] + 1;
        else if (!m_err) begin
          m_err    = 1'b1;
          m_err_id = 2'(i);
        end
      end
    end
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (m_pend[i] == MAXC);
    return b;
  endfunction

  initial begin
    int         wes;
    int         bad_grant;
    logic [3:0] r;
    logic       f;
    int         rpct;
    int         fpct;

    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0000, 1'b0, 1'b1, 4'b0001};
    tbl[2]  = '{4'b0000, 1'b0, 1'b1, 4'b0010};
    tbl[3]  = '{4'b0000, 1'b0, 1'b1, 4'b0100};
    tbl[4]  = '{4'b0000, 1'b0, 1'b1, 4'b1000};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0100, 1'b0, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0000, 1'b0, 1'b1, 4'b0100};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0000};
    tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0001};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000};
    tbl[13] = '{4'b0000, 1'b0, 1'b1, 4'b0010};
    tbl[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000};

    do_reset();
    chk("rst_we",     32'(bus.we), 32'd0);
    chk("rst_grant",  32'(bus.grant), 32'd0);
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_err",    32'(bus.err), 32'd0);
    chk("rst_err_id", 32'(bus.err_id), 32'd0);

    for (int v = 0; v < 15; v++) begin
      bus.req  = tbl[v].req;
      bus.full = tbl[v].full;
      tick();
      chk($sformatf("tbl%0d_we", v),    32'(bus.we),    32'(tbl[v].we));
      chk($sformatf("tbl%0d_grant", v), 32'(bus.grant), 32'(tbl[v].grant));
      chk($sformatf("tbl%0d_busy", v),  32'(bus.busy),  32'd0);
    end

    // Saturation of requester 3 while the FIFO reports full.
    bus.full = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      bus.req = 4'b1000;
      tick();
      chk($sformatf("sat%0d_busy", k), 32'(bus.busy), (k == 15) ? 32'h8 : 32'h0);
      chk($sformatf("sat%0d_we", k),   32'(bus.we), 32'd0);
      chk($sformatf("sat%0d_err", k),  32'(bus.err), 32'd0);
    end
    bus.req = 4'b1000;
    tick();
    chk("drop_err",    32'(bus.err), 32'd1);
    chk("drop_err_id", 32'(bus.err_id), 32'd3);
    chk("drop_busy",   32'(bus.busy), 32'h8);
    bus.req  = '0;
    bus.full = 1'b0;
    wes = 0; bad_grant = 0;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (k == 0) chk("drain_busy", 32'(bus.busy), 32'd0);
      if (bus.we) begin
        wes++;
        if (bus.grant != 4'b1000) bad_grant++;
      end
    end
    chk("drain_we_count", 32'(wes), 32'd15);
    chk("drain_grant",    32'(bad_grant), 32'd0);
    chk("drain_err_sticky", 32'(bus.err), 32'd1);

    // Async reset mid-burst with pend[1]=5 and requester 3 saturated.
    bus.full = 1'b1;
    for (int k = 0; k < 15; k++) begin
      bus.req = (k < 5) ? 4'b1010 : 4'b1000;
      tick();
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'h8);
    bus.req  = '0;
    bus.full = 1'b0;
    tick();
    chk("pre_rst_we",    32'(bus.we), 32'd1);
    chk("pre_rst_grant", 32'(bus.grant), 32'h2);
    #4;
    reset_l = 1'b0;
    #1;
    chk("async_we",     32'(bus.we), 32'd0);
    chk("async_grant",  32'(bus.grant), 32'd0);
    chk("async_busy",   32'(bus.busy), 32'd0);
    chk("async_err",    32'(bus.err), 32'd0);
    chk("async_err_id", 32'(bus.err_id), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_l = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst%0d_we", k), 32'(bus.we), 32'd0);
    end

    // Random traffic against the reference model, light then heavy backpressure.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      rpct = (c < 400) ? 30 : 70;
      fpct = (c < 400) ? 15 : 85;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < rpct);
      f = ($urandom_range(0, 99) < fpct);
      bus.req  = r;
      bus.full = f;
      tick();
      model_step(r, f);
      chk($sformatf("rnd%0d_we", c),     32'(bus.we),     32'(m_we));
      chk($sformatf("rnd%0d_grant", c),  32'(bus.grant),  32'(m_grant));
      chk($sformatf("rnd%0d_busy", c),   32'(bus.busy),   32'(model_busy()));
      chk($sformatf("rnd%0d_err", c),    32'(bus.err),    32'(m_err));
      chk($sformatf("rnd%0d_err_id", c), 32'(bus.err_id), 32'(m_err_id));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
